// File: rtl/dbus_uncached_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dbus_uncached_bridge: single-beat uncached path from dbus to cbus (MMIO).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

package common;
  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;
  typedef logic [2:0]  msize_t;
  typedef logic [3:0]  mlen_t;
  typedef logic [1:0]  axi_burst_type_t;

  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;
  localparam mlen_t MLEN1 = 4'd0;
  localparam axi_burst_type_t AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    addr_t           addr;
    strobe_t         strobe;
    word_t           data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;
endpackage

module dbus_uncached_bridge
  import common::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter logic [63:0] TIMEOUT_DATA   = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam bit          TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);

  state_t      state_q, state_d;
  addr_t       addr_q, addr_d;
  msize_t      size_q, size_d;
  strobe_t     strobe_q, strobe_d;
  word_t       wdata_q, wdata_d;
  logic        is_write_q, is_write_d;
  word_t       rdata_q, rdata_d;
  logic [15:0] count_q, count_d;
  logic        tflag_q, tflag_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      strobe_q   <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      rdata_q    <= '0;
      count_q    <= '0;
      tflag_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      strobe_q   <= strobe_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      rdata_q    <= rdata_d;
      count_q    <= count_d;
      tflag_q    <= tflag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    strobe_d   = strobe_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    rdata_d    = rdata_q;
    count_d    = count_q;
    tflag_d    = tflag_q;
    case (state_q)
      IDLE: begin
        count_d = '0;
        tflag_d = 1'b0;
        if (dreq.valid) begin
          addr_d     = dreq.addr;
          size_d     = dreq.size;
          strobe_d   = dreq.strobe;
          wdata_d    = dreq.data;
          is_write_d = |dreq.strobe;
          state_d    = REQ;
        end
      end
      REQ: begin
        count_d = count_q + 16'd1;
        // A completing beat takes priority over an expiring timeout.
        if (cresp.ready && cresp.last) begin
          rdata_d = is_write_q ? '0 : cresp.data;
          tflag_d = 1'b0;
          state_d = RESP;
        end else if (TIMEOUT_EN && (count_q == TIMEOUT_LIMIT)) begin
          rdata_d = is_write_q ? '0 : TIMEOUT_DATA;
          tflag_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the state register only, so reset clears them without a clock.
  always_comb begin
    creq    = '0;
    dresp   = '0;
    timeout = 1'b0;
    busy    = (state_q != IDLE);
    if (state_q == REQ) begin
      creq.valid    = 1'b1;
      creq.is_write = is_write_q;
      creq.size     = size_q;
      creq.addr     = addr_q;
      creq.strobe   = strobe_q;
      creq.data     = wdata_q;
      creq.len      = MLEN1;
      creq.burst    = AXI_BURST_INCR;
    end
    if (state_q == RESP) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = rdata_q;
      timeout       = tflag_q;
    end
  end

endmodule
`default_nettype wire

// File: doc/dbus_uncached_bridge.md
# dbus_uncached_bridge

Uncached responder for the data-cache bus. Accepts one `dbus_req_t` transaction from the CPU memory stage and completes it as a single-beat `cbus_req_t` transaction toward the AXI-side arbiter. It answers with a registered `dbus_resp_t`. It sits in parallel with the D-cache and serves MMIO and other uncached regions; address decode is done upstream.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 0: maximum cycles to wait in REQ for `cresp.ready && cresp.last`. 0 disables the timeout. Width of internal counter is 16 bits; values above 65535 are illegal.
- `TIMEOUT_DATA`, default 64'hDEAD_BEEF_DEAD_BEEF: read data returned on timeout.

Ports (from package `common`):
- Clocking: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `dreq`  in  `dbus_req_t`  CPU request.
- `dresp`  out  `dbus_resp_t`  response to CPU.
- `creq`  out  `cbus_req_t`  request to bus arbiter.
- `cresp`  in  `cbus_resp_t`  bus response.
- `busy`  out  1  high in any state other than IDLE.
- `timeout`  out  1  one-cycle pulse, coincident with the `dresp` that ends a timed-out transaction.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE
  - If `dreq.valid` is 1, latch `addr`, `size`, `strobe`, `data` and go to REQ.
  - Latch `is_write` as `|dreq.strobe`.
  - Clear the wait counter.
- REQ
  - Drive `creq.valid`=1 with the latched values: `addr`, `size`, `strobe`, `data`, `is_write`.
  - Also drive `len`=MLEN1 and `burst`=AXI_BURST_INCR.
  - On `cresp.ready && cresp.last`: latch `cresp.data` for reads, or 64'h0 for writes, and go to RESP.
  - `cresp.ready` without `last` is ignored and does not capture data. The bridge keeps waiting.
  - The wait counter increments every REQ cycle. If `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES` with no completing beat:
    - latch `TIMEOUT_DATA` for reads, or 0 for writes;
    - set the timeout flag;
    - go to RESP.
- RESP
  - Drive `dresp.addr_ok`=1, `dresp.data_ok`=1 and `dresp.data`=latched data, for exactly one cycle.
  - `timeout`=flag. Then go to IDLE.
- Latched request fields are frozen from acceptance until RESP ends. Changes to `dreq`, including `valid` dropping, do not affect the transaction in flight.
- Address and data are passed through unmodified. Strobe alignment is the CPU's responsibility (data sits in its 8-byte lane).
- Outputs in IDLE and RESP: `creq` is all zeros.
- Outputs outside RESP: `dresp` is all zeros and `timeout`=0.

## Timing
- Reset (asynchronous):
  - Immediately forces IDLE and clears every output: `creq`=0, `dresp`=0, `busy`=0, `timeout`=0.
  - Clears the latched fields, counter and flag.
  - A reset asserted in REQ drops `creq.valid` without waiting for the clock.
- Acceptance: with `dreq.valid` sampled at edge E0, `creq.valid` is high from E0 onward. It is registered, not combinational from `dreq`.
- Completion: with the final beat sampled at edge E1, `dresp.addr_ok`/`data_ok` are high from E1 to E2. `creq.valid` is low from E1.
- Minimum latency from `dreq.valid` to `data_ok` is 2 cycles (slave ready in the first REQ cycle).
- Back-to-back: the IDLE cycle after RESP can accept the next request. Peak throughput is one transaction per 3 cycles.
- Timeout: `data_ok` asserts exactly `TIMEOUT_CYCLES`+1 cycles after REQ entry.
- Simultaneous final beat and timeout expiry in the same cycle: the real beat wins (real data, `timeout`=0).

## Test plan
- Read: `dreq` = {valid=1, addr=0x4000_0008, size=MSIZE8, strobe=0}; slave returns data 0x1122_3344_5566_7788 with ready=last=1 after 3 cycles.
  - Expect `creq.is_write`=0, `len`=MLEN1, `addr` unchanged.
  - Expect `data_ok` one cycle after the beat, with `data`=0x1122_3344_5566_7788 for exactly one cycle.
- Write: strobe=8'b0000_0100, data=0x0000_0000_00CD_0000, addr=0x1F2.
  - Expect `creq.is_write`=1 with strobe and data passed unchanged.
  - Expect `dresp.data`=0 at completion.
- Request drop: deassert `dreq.valid` and change `dreq.addr` one cycle after acceptance.
  - Expect `creq.addr` to hold the original value and the transaction to complete normally.
  - Expect no new request until IDLE.
- Partial beats: ready=1, last=0 with data 0xAAAA…, then ready=1, last=1 with 0x5555….
  - Expect a single `data_ok` carrying 0x5555….
- Timeout: `TIMEOUT_CYCLES`=8, slave never ready.
  - Expect `data_ok` 9 cycles after REQ entry, `data`=0xDEAD_BEEF_DEAD_BEEF and `timeout`=1 for one cycle.
  - With `TIMEOUT_CYCLES`=0, expect `busy` to stay 1 indefinitely.
- Reset mid-REQ: assert `reset` between clock edges while `creq.valid`=1.
  - Expect `creq.valid` and `busy` to go to 0 before the next edge.
  - After release, a new read completes correctly, with no stale data or `timeout`.
